// File: rtl/counter_timer_arbiter_if.sv
// Request/grant bus between NREQ timed-interval requesters and the shared counter arbiter.
// Latency: none (pure signal bundle).
// Backpressure: a requester holds req_valid until req_ready; the arbiter accepts one at a time.
//
// Ports (signals):
//   req_valid [NREQ]      per-requester request
//   req_len   [NREQ*CW]   packed lengths, requester i at [i*CW +: CW]
//   req_ready [NREQ]      one-hot grant (combinational)
//   abort                 cancel the interval in progress
//   done      [NREQ]      one-cycle completion pulse to the owner
//   busy                  interval in progress (RUN or DONE)
//   owner     [IW]        current or last granted requester
//   cnt_q     [CW]        shared counter value
interface counter_timer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 3,
  parameter int IW   = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic               abort;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      cnt_q;

  // Requester side.
  modport master (
    output req_valid, req_len, abort,
    input  req_ready, done, busy, owner, cnt_q
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_len, abort,
    output req_ready, done, busy, owner, cnt_q
  );
endinterface

// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter that lends one CW-bit up-counter to NREQ requesters for timed intervals.
// Latency: grant in the request cycle; RUN lasts len+1 cycles; done pulses the cycle after RUN.
// Backpressure: req_ready only in IDLE, one requester at a time; others wait holding req_valid.
//
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   bus     counter_timer_arbiter_if.slave (request/grant, abort, done, status, counter value)
module counter_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  counter_timer_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_target;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last_grant;

  logic            w_grant_vld;
  logic [IW-1:0]   w_grant_idx;
  logic [IW-1:0]   w_scan;
  logic [CW-1:0]   w_len_sel;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_done;
  logic            w_at_target;

  assign w_at_target = (r_cnt == r_target);

  // Round-robin search: start just after the last granted index and wrap.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scan = IW'((int'(r_last_grant) + k) % NREQ);
      if (!w_grant_vld && bus.req_valid[w_scan]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  // Length of the winning requester, selected with constant slices.
  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IW'(i)) begin
        w_len_sel = bus.req_len[i*CW +: CW];
      end
    end
  end

  // Grant and done decode; both masked during reset so nothing handshakes or completes then.
  // abort in DONE suppresses the pulse in the same cycle.
  always_comb begin
    w_ready = '0;
    w_done  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ready[i] = !i_rst && (r_state == ST_IDLE) && w_grant_vld && (w_grant_idx == IW'(i));
      w_done[i]  = !i_rst && (r_state == ST_DONE) && !bus.abort && (r_owner == IW'(i));
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_at_target) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter, captured length and ownership bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_target     <= '0;
      r_owner      <= '0;
      r_last_grant <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_target <= w_len_sel;
            r_owner  <= w_grant_idx;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_cnt        <= '0;
            r_last_grant <= r_owner;
          end else if (!w_at_target) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_owner;
          if (bus.abort) begin
            r_cnt <= '0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.done      = w_done;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.owner     = r_owner;
  assign bus.cnt_q     = r_cnt;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Bench for counter_timer_arbiter: directed scenarios then randomized traffic vs. an interval model.
// Latency: inputs change 1 time unit after each rising edge; outputs compared on the falling edge.
// Backpressure: random requesters hold req_valid until granted (with occasional drops).
module tb_counter_timer_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

  counter_timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Interval model: an interval is "elapsed cycles since grant" plus its length.
  bit m_act   = 0;
  int m_e     = 0;
  int m_len   = 0;
  int m_owner = 0;
  int m_last  = NREQ - 1;
  int m_cnt   = 0;

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model over the next edge.
  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ*CW-1:0] l,
                      input logic a, output int g);
    int e_busy;
    int e_cnt;
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_done;
    @(posedge clk);
    #1;
    rst           = r;
    bus.req_valid = v;
    bus.req_len   = l;
    bus.abort     = a;
    @(negedge clk);
    g      = -1;
    e_rdy  = '0;
    e_done = '0;
    if (!m_act) begin
      g      = pick(v);
      e_busy = 0;
      e_cnt  = m_cnt;
      if (!r && g >= 0) e_rdy[g] = 1'b1;
    end else begin
      e_busy = 1;
      e_cnt  = (m_e <= m_len) ? m_e : m_len;
      if (m_e == m_len + 1 && !a && !r) e_done[m_owner] = 1'b1;
    end
    chk("req_ready", int'(bus.req_ready), int'(e_rdy));
    chk("done",      int'(bus.done),      int'(e_done));
    chk("busy",      int'(bus.busy),      e_busy);
    chk("owner",     int'(bus.owner),     m_owner);
    chk("cnt_q",     int'(bus.cnt_q),     e_cnt);
    if (r) begin
      m_act   = 0;
      m_cnt   = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
      g       = -1;
    end else if (!m_act) begin
      if (g >= 0) begin
        m_act   = 1;
        m_e     = 0;
        m_len   = int'(l[g*CW +: CW]);
        m_owner = g;
      end
    end else if (a) begin
      m_act  = 0;
      m_cnt  = 0;
      m_last = m_owner;
    end else if (m_e == m_len + 1) begin
      m_act  = 0;
      m_cnt  = m_len;
      m_last = m_owner;
    end else begin
      m_e++;
    end
  endtask

  task automatic idle_n(input int n);
    int g;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, g);
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] pend;
    logic [NREQ*CW-1:0] lens;
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.abort     = 1'b0;
    @(posedge clk);

    // Reset, then a single request of length 3.
    step(1'b1, '0, '0, 1'b0, g);
    step(1'b1, '0, '0, 1'b0, g);
    step(1'b0, 4'b0001, 12'o0003, 1'b0, g);
    idle_n(7);

    // Zero length on requester 2.
    step(1'b0, 4'b0100, 12'o0000, 1'b0, g);
    idle_n(3);

    // Fairness: all requesters held, all lengths 1.
    step(1'b1, '0, '0, 1'b0, g);
    for (int i = 0; i < 22; i++) step(1'b0, 4'b1111, 12'o1111, 1'b0, g);
    idle_n(2);

    // Maximum length, changing req_len after the handshake.
    step(1'b0, 4'b0001, 12'o0007, 1'b0, g);
    for (int i = 0; i < 11; i++) step(1'b0, '0, 12'o0000, 1'b0, g);

    // Abort when cnt_q==2 with requester 1 pending.
    step(1'b1, '0, '0, 1'b0, g);
    step(1'b0, 4'b0001, 12'o0005, 1'b0, g);
    step(1'b0, 4'b0010, 12'o0020, 1'b0, g);
    step(1'b0, 4'b0010, 12'o0020, 1'b0, g);
    step(1'b0, 4'b0010, 12'o0020, 1'b1, g);
    step(1'b0, 4'b0010, 12'o0020, 1'b0, g);
    idle_n(5);

    // Reset mid-run at cnt_q==4, then requesters 0 and 3 compete.
    step(1'b1, '0, '0, 1'b0, g);
    step(1'b0, 4'b0001, 12'o0007, 1'b0, g);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, g);
    step(1'b1, '0, '0, 1'b0, g);
    step(1'b0, 4'b1001, 12'o1001, 1'b0, g);
    idle_n(5);

    // Randomized traffic.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3) == 0) pend[i] = 1'b1;
      end
      if (($urandom % 40) == 0) pend[$urandom % NREQ] = 1'b0;
      lens = NREQ*CW'($urandom);
      step((($urandom % 97) == 0), pend, lens, (($urandom % 16) == 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
